// File: rtl/bus_addr_dec_ctrl_pkg.sv
// bus_addr_dec_ctrl_pkg: shared state encodings and error codes for the bus address decoder
package bus_addr_dec_ctrl_pkg;
    localparam logic [1:0] BUS_DEC_ST_IDLE   = 2'd0;
    localparam logic [1:0] BUS_DEC_ST_ACCESS = 2'd1;
    localparam logic [1:0] BUS_DEC_ST_ERROR  = 2'd2;
    localparam logic [1:0] BUS_DEC_ERR_NONE    = 2'd0;
    localparam logic [1:0] BUS_DEC_ERR_UNMAP   = 2'd1;
    localparam logic [1:0] BUS_DEC_ERR_TIMEOUT = 2'd2;
endpackage

// File: rtl/bus_addr_dec_ctrl_timer.sv
// bus_addr_dec_ctrl_timer: clearable enabled up-counter with terminal-count flag (only built with BUS_DEC_TIMEOUT_EN)
`ifdef BUS_DEC_TIMEOUT_EN
module bus_addr_dec_ctrl_timer #(
    parameter int MAX = 256
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tc
);
    logic [15:0] cnt;
    // count enabled cycles, restart from zero whenever cleared
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en) cnt <= cnt + 16'd1;
    end
    assign tc = cnt == 16'(MAX - 1);
endmodule
`endif

// File: rtl/bus_addr_dec_ctrl.sv
// bus_addr_dec_ctrl: registered chip-select decoder with unmapped/timeout bus error (timeout path under BUS_DEC_TIMEOUT_EN)
module bus_addr_dec_ctrl
    import bus_addr_dec_ctrl_pkg::*;
#(
    parameter int ADDR_W    = 30,
    parameter int IDX_MSB   = 29,
    parameter int IDX_LSB   = 27,
    parameter int SLAVE_NUM = 8,
    parameter logic [SLAVE_NUM-1:0] SLAVE_MASK = {SLAVE_NUM{1'b1}},
    parameter int TIMEOUT   = 256,
    localparam int IDX_W    = IDX_MSB - IDX_LSB + 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 s_as_,
    input  logic [ADDR_W-1:0]    s_addr,
    input  logic [SLAVE_NUM-1:0] s_rdy_in_,
    output logic [SLAVE_NUM-1:0] s_cs_,
    output logic                 m_rdy_,
    output logic                 m_err,
    output logic [1:0]           err_cause,
    output logic [IDX_W-1:0]     err_idx
);
    if (SLAVE_NUM < 1 || SLAVE_NUM > 2**IDX_W) begin : g_bad_slave_num
        $error("SLAVE_NUM out of range for index field");
    end
    if (TIMEOUT < 2 || TIMEOUT > 65535) begin : g_bad_timeout
        $error("TIMEOUT must be 2..65535");
    end
    logic [1:0]       state;
    logic [IDX_W-1:0] sel;
    logic [IDX_W-1:0] idx;
    logic             mapped;
    logic             rdy_sel;
    logic             timeout_hit;
    logic             unused_addr;
    assign idx         = s_addr[IDX_MSB:IDX_LSB];
    assign unused_addr = ^s_addr;
    assign rdy_sel     = s_rdy_in_[sel];
    // an index is mapped when it names a populated slave
    always_comb begin
        mapped = 1'b0;
        for (int i = 0; i < SLAVE_NUM; i++)
            if (idx == IDX_W'(i) && SLAVE_MASK[i]) mapped = 1'b1;
    end
`ifdef BUS_DEC_TIMEOUT_EN
    bus_addr_dec_ctrl_timer #(.MAX(TIMEOUT)) u_timer (
        .clk  (clk),
        .reset(reset),
        .clr  (state != BUS_DEC_ST_ACCESS),
        .en   (state == BUS_DEC_ST_ACCESS && rdy_sel),
        .tc   (timeout_hit)
    );
`else
    assign timeout_hit = 1'b0;
`endif
    // transaction FSM: decode in IDLE, hold chip-select in ACCESS, one-cycle ERROR response
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= BUS_DEC_ST_IDLE;
            sel       <= '0;
            s_cs_     <= '1;
            err_cause <= BUS_DEC_ERR_NONE;
            err_idx   <= '0;
        end else begin
            case (state)
                BUS_DEC_ST_IDLE: begin
                    if (!s_as_ && mapped) begin
                        state <= BUS_DEC_ST_ACCESS;
                        sel   <= idx;
                        s_cs_ <= ~(SLAVE_NUM'(1) << idx);
                    end else if (!s_as_) begin
                        state     <= BUS_DEC_ST_ERROR;
                        err_cause <= BUS_DEC_ERR_UNMAP;
                        err_idx   <= idx;
                    end
                end
                BUS_DEC_ST_ACCESS: begin
                    if (!rdy_sel) begin
                        state <= BUS_DEC_ST_IDLE;
                        s_cs_ <= '1;
                    end else if (timeout_hit) begin
                        state     <= BUS_DEC_ST_ERROR;
                        s_cs_     <= '1;
                        err_cause <= BUS_DEC_ERR_TIMEOUT;
                        err_idx   <= sel;
                    end
                end
                default: begin
                    state <= BUS_DEC_ST_IDLE;
                    s_cs_ <= '1;
                end
            endcase
        end
    end
    assign m_rdy_ = (state == BUS_DEC_ST_ACCESS) ? rdy_sel : (state != BUS_DEC_ST_ERROR);
    assign m_err  = state == BUS_DEC_ST_ERROR;
`ifndef SYNTHESIS
    // never more than one slave selected at once
    always_ff @(posedge clk) begin
        if (reset) assert ($onehot0(~s_cs_));
    end
`endif
endmodule

// File: tb/tb_bus_addr_dec_ctrl.sv
// tb_bus_addr_dec_ctrl: scoreboard bench for bus_addr_dec_ctrl (SLAVE_MASK 8'h7F, TIMEOUT 4)
module tb_bus_addr_dec_ctrl;
    typedef struct packed {
        logic       as_;
        logic [2:0] idx;
        logic [7:0] rdy;
        logic [7:0] cs;
        logic       mr;
        logic       me;
    } vec_t;
    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        s_as_ = 1'b1;
    logic [29:0] s_addr = '0;
    logic [7:0]  s_rdy_in_ = '1;
    logic [7:0]  s_cs_;
    logic        m_rdy_;
    logic        m_err;
    logic [1:0]  err_cause;
    logic [2:0]  err_idx;
    logic [9:0]  q[$];
    logic [9:0]  e;
    int vectors = 0;
    int miscompares = 0;
    bus_addr_dec_ctrl #(.SLAVE_MASK(8'h7F), .TIMEOUT(4)) dut (
        .clk(clk), .reset(reset), .s_as_(s_as_), .s_addr(s_addr), .s_rdy_in_(s_rdy_in_),
        .s_cs_(s_cs_), .m_rdy_(m_rdy_), .m_err(m_err), .err_cause(err_cause), .err_idx(err_idx)
    );
    always #5 clk = ~clk;
    task automatic apply(input vec_t v);
        @(negedge clk);
        s_as_     = v.as_;
        s_addr    = {v.idx, 27'h0};
        s_rdy_in_ = v.rdy;
        q.push_back({v.cs, v.mr, v.me});
        #1;
    endtask
    task automatic test_reset;
        reset = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        vectors++;
        if ({s_cs_, m_rdy_, m_err} !== {8'hFF, 1'b1, 1'b0}) begin
            miscompares++;
            $display("FAIL reset outputs: cs/rdy/err got %h/%b/%b want ff/1/0", s_cs_, m_rdy_, m_err);
        end
        vectors++;
        if ({err_cause, err_idx} !== 5'b0) begin
            miscompares++;
            $display("FAIL reset sticky: cause/idx got %b/%0d want 00/0", err_cause, err_idx);
        end
        reset = 1'b1;
    endtask
    task automatic test_access;
        vec_t t[5] = '{
            '{1'b0, 3'd3, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b1, 3'd3, 8'hFF, 8'hF7, 1'b1, 1'b0},
            '{1'b1, 3'd3, 8'hFF, 8'hF7, 1'b1, 1'b0},
            '{1'b1, 3'd3, 8'hF7, 8'hF7, 1'b0, 1'b0},
            '{1'b1, 3'd3, 8'hFF, 8'hFF, 1'b1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(t[i]);
            e = q.pop_front();
            vectors++;
            if ({s_cs_, m_rdy_, m_err} !== e) begin
                miscompares++;
                $display("FAIL access[%0d]: cs/rdy/err got %h/%b/%b want %h/%b/%b", i, s_cs_, m_rdy_, m_err, e[9:2], e[1], e[0]);
            end
        end
        vectors++;
        if (err_cause !== 2'b00) begin
            miscompares++;
            $display("FAIL access cause: got %b want 00", err_cause);
        end
    endtask
    task automatic test_unmapped;
        vec_t t[3] = '{
            '{1'b0, 3'd7, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b1, 3'd7, 8'hFF, 8'hFF, 1'b0, 1'b1},
            '{1'b1, 3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0}};
        for (int i = 0; i < 3; i++) begin
            apply(t[i]);
            e = q.pop_front();
            vectors++;
            if ({s_cs_, m_rdy_, m_err} !== e) begin
                miscompares++;
                $display("FAIL unmapped[%0d]: cs/rdy/err got %h/%b/%b want %h/%b/%b", i, s_cs_, m_rdy_, m_err, e[9:2], e[1], e[0]);
            end
        end
        vectors++;
        if ({err_cause, err_idx} !== {2'b01, 3'd7}) begin
            miscompares++;
            $display("FAIL unmapped sticky: cause/idx got %b/%0d want 01/7", err_cause, err_idx);
        end
    endtask
    task automatic test_other_ready;
        vec_t t[6] = '{
            '{1'b0, 3'd1, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b0, 3'd5, 8'hFF, 8'hFD, 1'b1, 1'b0},
            '{1'b0, 3'd5, 8'hDF, 8'hFD, 1'b1, 1'b0},
            '{1'b0, 3'd5, 8'hDF, 8'hFD, 1'b1, 1'b0},
            '{1'b0, 3'd5, 8'hFD, 8'hFD, 1'b0, 1'b0},
            '{1'b1, 3'd5, 8'hFF, 8'hFF, 1'b1, 1'b0}};
        for (int i = 0; i < 6; i++) begin
            apply(t[i]);
            e = q.pop_front();
            vectors++;
            if ({s_cs_, m_rdy_, m_err} !== e) begin
                miscompares++;
                $display("FAIL other_ready[%0d]: cs/rdy/err got %h/%b/%b want %h/%b/%b", i, s_cs_, m_rdy_, m_err, e[9:2], e[1], e[0]);
            end
        end
    endtask
`ifdef BUS_DEC_TIMEOUT_EN
    task automatic test_timeout;
        vec_t t[13] = '{
            '{1'b0, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFF, 1'b0, 1'b1},
            '{1'b1, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b0, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0},
            '{1'b1, 3'd2, 8'hFB, 8'hFB, 1'b0, 1'b0},
            '{1'b1, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0}};
        for (int i = 0; i < 13; i++) begin
            apply(t[i]);
            e = q.pop_front();
            vectors++;
            if ({s_cs_, m_rdy_, m_err} !== e) begin
                miscompares++;
                $display("FAIL timeout[%0d]: cs/rdy/err got %h/%b/%b want %h/%b/%b", i, s_cs_, m_rdy_, m_err, e[9:2], e[1], e[0]);
            end
            if (i == 6 || i == 12) begin
                vectors++;
                if ({err_cause, err_idx} !== {2'b10, 3'd2}) begin
                    miscompares++;
                    $display("FAIL timeout sticky[%0d]: cause/idx got %b/%0d want 10/2", i, err_cause, err_idx);
                end
            end
        end
    endtask
`else
    task automatic test_no_timeout;
        vec_t t;
        for (int i = 0; i < 1003; i++) begin
            t = (i == 0) ? '{1'b0, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0} :
                (i == 1001) ? '{1'b1, 3'd2, 8'hFB, 8'hFB, 1'b0, 1'b0} :
                (i == 1002) ? '{1'b1, 3'd2, 8'hFF, 8'hFF, 1'b1, 1'b0} :
                '{1'b1, 3'd2, 8'hFF, 8'hFB, 1'b1, 1'b0};
            apply(t);
            e = q.pop_front();
            vectors++;
            if ({s_cs_, m_rdy_, m_err} !== e) begin
                miscompares++;
                $display("FAIL no_timeout[%0d]: cs/rdy/err got %h/%b/%b want %h/%b/%b", i, s_cs_, m_rdy_, m_err, e[9:2], e[1], e[0]);
            end
        end
        vectors++;
        if ({err_cause, err_idx} !== {2'b01, 3'd7}) begin
            miscompares++;
            $display("FAIL no_timeout sticky: cause/idx got %b/%0d want 01/7", err_cause, err_idx);
        end
    endtask
`endif
    task automatic test_back_to_back;
        vec_t t[5] = '{
            '{1'b0, 3'd0, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b0, 3'd0, 8'hFE, 8'hFE, 1'b0, 1'b0},
            '{1'b0, 3'd6, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b0, 3'd6, 8'hBF, 8'hBF, 1'b0, 1'b0},
            '{1'b1, 3'd6, 8'hFF, 8'hFF, 1'b1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(t[i]);
            e = q.pop_front();
            vectors++;
            if ({s_cs_, m_rdy_, m_err} !== e) begin
                miscompares++;
                $display("FAIL back_to_back[%0d]: cs/rdy/err got %h/%b/%b want %h/%b/%b", i, s_cs_, m_rdy_, m_err, e[9:2], e[1], e[0]);
            end
        end
    endtask
    task automatic test_mid_reset;
        vec_t t[5] = '{
            '{1'b0, 3'd4, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b1, 3'd4, 8'hFF, 8'hEF, 1'b1, 1'b0},
            '{1'b0, 3'd4, 8'hFF, 8'hFF, 1'b1, 1'b0},
            '{1'b1, 3'd4, 8'hEF, 8'hEF, 1'b0, 1'b0},
            '{1'b1, 3'd4, 8'hFF, 8'hFF, 1'b1, 1'b0}};
        for (int i = 0; i < 5; i++) begin
            apply(t[i]);
            e = q.pop_front();
            vectors++;
            if ({s_cs_, m_rdy_, m_err} !== e) begin
                miscompares++;
                $display("FAIL mid_reset[%0d]: cs/rdy/err got %h/%b/%b want %h/%b/%b", i, s_cs_, m_rdy_, m_err, e[9:2], e[1], e[0]);
            end
            if (i == 1) begin
                @(negedge clk);
                reset = 1'b0;
                #1;
                vectors++;
                if ({s_cs_, m_rdy_, m_err} !== {8'hFF, 1'b1, 1'b0}) begin
                    miscompares++;
                    $display("FAIL mid_reset abort: cs/rdy/err got %h/%b/%b want ff/1/0", s_cs_, m_rdy_, m_err);
                end
                @(negedge clk);
                vectors++;
                if ({m_rdy_, err_cause} !== {1'b1, 2'b00}) begin
                    miscompares++;
                    $display("FAIL mid_reset hold: rdy/cause got %b/%b want 1/00", m_rdy_, err_cause);
                end
                reset = 1'b1;
            end
        end
    endtask
    initial begin
        test_reset();
        test_access();
        test_unmapped();
        test_other_ready();
`ifdef BUS_DEC_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        test_back_to_back();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
